clut_fade_ctrl: RTL and testbench

Sequencer that fills the colour lookup table from a source palette. Each entry is scaled by a brightness level, and the level steps once per pass to produce frame-synchronous fade-in and fade-out effects. It sits between a palette ROM/RAM (synchronous read) and the CLUT write port. A pass starts only on a frame pulse, so every pass runs inside vertical blanking.

---
 rtl/clut_fade_ctrl.sv | 136 +++++++++++++
 tb/tb_clut_fade_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clut_fade_ctrl.sv
// clut_fade_ctrl: copies a source palette into the CLUT once per pass,
// scaling each R/G/B channel by a brightness level that steps one unit per
// pass. Passes are launched only on a frame pulse, so writes land in blanking.
//
// state | meaning
// IDLE  | no fade in progress, waiting for start
// WAIT  | fade active, counting frame pulses until the next pass
// COPY  | issuing source reads for indices 0..N-1, one per cycle
// DRAIN | two cycles for the last reads to reach the CLUT, then step level

module clut_fade_ctrl #(
   parameter int COLRW       = 12,
   parameter int CHANW       = 4,
   parameter int CIDXW       = 4,
   parameter int STEP_FRAMES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic             frame,
   output logic [CIDXW-1:0] src_addr,
   input  logic [COLRW-1:0] src_data,
   output logic             clut_we,
   output logic [CIDXW-1:0] clut_cidx,
   output logic [COLRW-1:0] clut_colr,
   output logic [4:0]       level,
   output logic             busy,
   output logic             done
);

   localparam int FCW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
   localparam logic [FCW-1:0]   FRELOAD = FCW'(STEP_FRAMES - 1);
   localparam logic [CIDXW-1:0] LAST    = '1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COPY, S_DRAIN} state_t;

   state_t           state;
   logic             dir_q;
   logic [FCW-1:0]   fcnt;
   logic [CIDXW-1:0] addr;
   logic             drain_cnt;
   logic             rd_valid;
   logic [CIDXW-1:0] rd_idx;
   logic [4:0]       target;
   logic [COLRW-1:0] scaled;

   assign target   = dir_q ? 5'd16 : 5'd0;
   assign src_addr = addr;

   // Per-channel scale: full-precision product, keep the integer part (>> 4).
   for (genvar g = 0; g < 3; g++) begin : g_chan
      logic [CHANW+4:0] prod;
      assign prod = (CHANW+5)'(src_data[g*CHANW +: CHANW]) * (CHANW+5)'(level);
      assign scaled[g*CHANW +: CHANW] = CHANW'(prod >> 4);
   end

   // Read pipeline: address issued in t, data in t+1, CLUT write registered for t+2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid  <= 1'b0;
         rd_idx    <= '0;
         clut_we   <= 1'b0;
         clut_cidx <= '0;
         clut_colr <= '0;
      end else begin
         rd_valid <= (state == S_COPY);
         rd_idx   <= addr;
         clut_we  <= rd_valid;
         if (rd_valid) begin
            clut_cidx <= rd_idx;
            clut_colr <= scaled;
         end
      end
   end

   // Pass sequencer: frame pacing, address generation and level stepping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         dir_q     <= 1'b0;
         fcnt      <= '0;
         addr      <= '0;
         drain_cnt <= 1'b0;
         level     <= 5'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  dir_q <= dir;
                  level <= dir ? 5'd0 : 5'd16;
                  fcnt  <= '0;
                  busy  <= 1'b1;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (frame) begin
                  if (fcnt == '0) begin
                     addr  <= '0;
                     state <= S_COPY;
                  end else begin
                     fcnt <= fcnt - 1'b1;
                  end
               end
            end
            S_COPY: begin
               // wraps N-1 -> 0 on the exit cycle, leaving addr ready for the next pass
               addr <= addr + 1'b1;
               if (addr == LAST) begin
                  drain_cnt <= 1'b0;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!drain_cnt) begin
                  drain_cnt <= 1'b1;
               end else if (level == target) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  level <= dir_q ? level + 5'd1 : level - 5'd1;
                  fcnt  <= FRELOAD;
                  state <= S_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clut_fade_ctrl.sv
// Directed bench for clut_fade_ctrl: dut_a (STEP_FRAMES=1) covers fades,
// scaling, start-while-busy and reset; dut_b (STEP_FRAMES=3) covers cadence.

module tb_clut_fade_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, dir_a, frame_a, we_a, busy_a, done_a;
   logic [3:0]  src_addr_a, cidx_a;
   logic [11:0] src_data_a, colr_a;
   logic [4:0]  level_a;
   logic        start_b, dir_b, frame_b, we_b, busy_b, done_b;
   logic [3:0]  src_addr_b, cidx_b;
   logic [11:0] src_data_b, colr_b;
   logic [4:0]  level_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [11:0] cap [0:16][0:15];

   clut_fade_ctrl #(.COLRW(12), .CHANW(4), .CIDXW(4), .STEP_FRAMES(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .dir(dir_a), .frame(frame_a),
      .src_addr(src_addr_a), .src_data(src_data_a),
      .clut_we(we_a), .clut_cidx(cidx_a), .clut_colr(colr_a),
      .level(level_a), .busy(busy_a), .done(done_a));

   clut_fade_ctrl #(.COLRW(12), .CHANW(4), .CIDXW(4), .STEP_FRAMES(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .dir(dir_b), .frame(frame_b),
      .src_addr(src_addr_b), .src_data(src_data_b),
      .clut_we(we_b), .clut_cidx(cidx_b), .clut_colr(colr_b),
      .level(level_b), .busy(busy_b), .done(done_b));

   function automatic logic [11:0] pal_a(input logic [3:0] i);
      case (i)
         4'd3:    return 12'hF84;
         4'd5:    return 12'hFFF;
         default: return 12'(i) * 12'h111;
      endcase
   endfunction

   function automatic logic [11:0] scale(input logic [11:0] c, input int lvl);
      logic [11:0] r;
      r = '0;
      for (int k = 0; k < 3; k++) r[k*4 +: 4] = 4'((int'(c[k*4 +: 4]) * lvl) / 16);
      return r;
   endfunction

   // synchronous-read source palettes
   always @(posedge clk) begin
      src_data_a <= pal_a(src_addr_a);
      src_data_b <= 12'(src_addr_b) * 12'h111;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_level"}, 32'(level_a), 32'd0);
      chk({tag, "_busy"},  32'(busy_a),  32'd0);
      chk({tag, "_done"},  32'(done_a),  32'd0);
      chk({tag, "_we"},    32'(we_a),    32'd0);
      chk({tag, "_cidx"},  32'(cidx_a),  32'd0);
      chk({tag, "_colr"},  32'(colr_a),  32'd0);
      chk({tag, "_saddr"}, 32'(src_addr_a), 32'd0);
   endtask

   // One pass on dut_a: frame in cycle f, writes expected in f+3..f+18, end in f+19.
   task automatic run_pass_a(input int lvl, input bit last);
      @(negedge clk);
      frame_a = 1'b1;
      chk($sformatf("wait_level_L%0d", lvl), 32'(level_a), 32'(lvl));
      @(negedge clk);
      frame_a = 1'b0;
      chk("pre_we1", 32'(we_a), 32'd0);
      @(negedge clk);
      chk("pre_we2", 32'(we_a), 32'd0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk($sformatf("we_L%0d_i%0d", lvl, k), 32'(we_a), 32'd1);
         chk($sformatf("cidx_L%0d_i%0d", lvl, k), 32'(cidx_a), 32'(k));
         chk($sformatf("colr_L%0d_i%0d", lvl, k), 32'(colr_a),
             32'(scale(pal_a(4'(k)), lvl)));
         cap[lvl][k] = colr_a;
      end
      @(negedge clk);
      chk($sformatf("post_we_L%0d", lvl), 32'(we_a), 32'd0);
      chk($sformatf("done_L%0d", lvl), 32'(done_a), 32'(last));
      chk($sformatf("busy_L%0d", lvl), 32'(busy_a), 32'(!last));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, first, lvl_seen;
      bit order_ok, is_pass;
      rst = 1'b1;
      start_a = 1'b0; dir_a = 1'b0; frame_a = 1'b0;
      start_b = 1'b0; dir_b = 1'b0; frame_b = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_a("rst");
      rst = 1'b0;

      // fade in; start and frame in the same cycle: that frame must not launch a pass
      @(negedge clk);
      start_a = 1'b1; dir_a = 1'b1; frame_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; frame_a = 1'b0;
      chk("in_busy_rise", 32'(busy_a), 32'd1);
      chk("in_level0", 32'(level_a), 32'd0);
      repeat (4) @(negedge clk);
      chk("no_early_pass", 32'(we_a), 32'd0);
      for (int p = 0; p <= 16; p++) run_pass_a(p, p == 16);
      @(negedge clk);
      chk("in_done_once", 32'(done_a), 32'd0);
      chk("in_busy_low", 32'(busy_a), 32'd0);
      chk("in_level_end", 32'(level_a), 32'd16);
      chk("f84_l8",  32'(cap[8][3]),  32'h742);
      chk("f84_l16", 32'(cap[16][3]), 32'hF84);
      chk("f84_l1",  32'(cap[1][3]),  32'h000);
      chk("fff_l15", 32'(cap[15][5]), 32'hEEE);
      chk("i7_l16",  32'(cap[16][7]), 32'h777);
      chk("i10_l0",  32'(cap[0][10]), 32'h000);

      // fade out; an opposite-direction start mid-fade must be ignored
      @(negedge clk);
      start_a = 1'b1; dir_a = 1'b0;
      chk("out_busy_before", 32'(busy_a), 32'd0);
      @(negedge clk);
      start_a = 1'b0;
      chk("out_busy_rise", 32'(busy_a), 32'd1);
      chk("out_level16", 32'(level_a), 32'd16);
      for (int p = 0; p <= 16; p++) begin
         run_pass_a(16 - p, p == 16);
         if (p == 4) begin
            @(negedge clk);
            start_a = 1'b1; dir_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
         end
      end
      @(negedge clk);
      chk("out_done_once", 32'(done_a), 32'd0);
      chk("out_busy_low", 32'(busy_a), 32'd0);
      chk("out_level_end", 32'(level_a), 32'd0);

      // cadence on dut_b: passes on frame pulses 1,4,7,10; extra pulses in COPY/DRAIN
      @(negedge clk);
      start_b = 1'b1; dir_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         is_pass = (j % 3 == 1);
         cnt = 0; first = -1; order_ok = 1'b1; lvl_seen = -1;
         @(negedge clk);
         frame_b = 1'b1;
         for (int o = 1; o <= 23; o++) begin
            @(negedge clk);
            frame_b = is_pass && (o == 8 || o == 17);
            if (we_b) begin
               if (first < 0) begin
                  first = o;
                  lvl_seen = int'(level_b);
               end
               if (int'(cidx_b) != cnt) order_ok = 1'b0;
               cnt++;
            end
         end
         chk($sformatf("cad_cnt_f%0d", j), 32'(cnt), is_pass ? 32'd16 : 32'd0);
         if (is_pass) begin
            chk($sformatf("cad_first_f%0d", j), 32'(first), 32'd3);
            chk($sformatf("cad_order_f%0d", j), 32'(order_ok), 32'd1);
            chk($sformatf("cad_level_f%0d", j), 32'(lvl_seen), 32'((j - 1) / 3));
         end
      end

      // reset during pass 5 at cidx 7, then restart from the initial level
      @(negedge clk);
      start_a = 1'b1; dir_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int p = 0; p < 4; p++) run_pass_a(p, 1'b0);
      @(negedge clk);
      frame_a = 1'b1;
      @(negedge clk);
      frame_a = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_we", 32'(we_a), 32'd1);
      chk("mid_cidx", 32'(cidx_a), 32'd7);
      chk("mid_level", 32'(level_a), 32'd4);
      rst = 1'b1;
      #1;
      chk_reset_a("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_a = 1'b1; dir_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("restart_busy", 32'(busy_a), 32'd1);
      chk("restart_level", 32'(level_a), 32'd0);
      run_pass_a(0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
